// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; flags each completed word
// with a registered one-cycle pulse alongside the registered word.
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_last,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q,   cnt_d;
  logic [23:0] shreg_q, shreg_d;
  logic [31:0] word_q,  word_d;
  logic        valid_q, valid_d;

  assign word_last  = byte_valid && (cnt_q == 2'd3);
  assign word_valid = valid_q;
  assign word       = word_q;

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clr) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (byte_valid) begin
      cnt_d   = cnt_q + 2'd1;
      // Newest byte enters at the top so byte 0 ends up in the low lane.
      shreg_d = {byte_in, shreg_q[23:8]};
      if (cnt_q == 2'd3) begin
        word_d  = {byte_in, shreg_q};
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length/payload/checksum byte frame, writes imem words,
// and releases the core from reset only after a verified image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic              core_rst
);

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [1:0]        err_q, err_d;
  logic              rx_ready_q, rx_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              core_rst_q, core_rst_d;

  logic              accept;
  logic              pk_valid;
  logic              pk_clr;
  logic              word_last;
  logic [15:0]       len_new;

  assign accept   = rx_valid && rx_ready_q;
  assign pk_valid = accept && (state_q == DATA);
  assign len_new  = {rx_data, len_lo_q};

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .byte_valid (pk_valid),
    .byte_in    (rx_data),
    .word_last  (word_last),
    .word_valid (we),
    .word       (wdata)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    wcnt_d   = wcnt_q;
    csum_d   = csum_q;
    waddr_d  = waddr_q;
    err_d    = err_q;
    pk_clr   = 1'b0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN0;
          wcnt_d  = '0;
          csum_d  = '0;
          err_d   = ERR_NONE;
          pk_clr  = 1'b1;
        end
      end
      LEN0: begin
        if (accept) begin
          len_lo_d = rx_data;
          csum_d   = csum_q ^ rx_data;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          len_d  = len_new;
          csum_d = csum_q ^ rx_data;
          if (int'(len_new) > IMEM_WORDS) begin
            state_d = ERR;
            err_d   = ERR_LEN;
          end else if (len_new == '0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
          if (word_last) begin
            wcnt_d  = wcnt_q + 16'd1;
            waddr_d = wcnt_q[ADDR_W-1:0];
            if (wcnt_q == len_q - 16'd1) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERR;
            err_d   = ERR_CSUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    rx_ready_d = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA) || (state_d == CSUM);
    busy_d     = rx_ready_d;
    done_d     = (state_d == DONE);
    core_rst_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      wcnt_q     <= '0;
      csum_q     <= '0;
      waddr_q    <= '0;
      err_q      <= ERR_NONE;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      csum_q     <= csum_d;
      waddr_q    <= waddr_d;
      err_q      <= err_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign waddr    = waddr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_code = err_q;
  assign core_rst = core_rst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as frames are built.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        we;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic        core_rst;

  int vectors    = 0;
  int miscompares = 0;

  logic [39:0] sb[$];
  logic [7:0]  fq[$];

  always #5 clk = ~clk;

  imem_loader #(.IMEM_WORDS(256), .ADDR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err_code (err_code),
    .core_rst (core_rst)
  );

  // Write-port monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_we: got addr=%0d data=%h, required no write", waddr, wdata);
      end else begin
        logic [39:0] exp;
        exp = sb.pop_front();
        if ({waddr, wdata} !== exp) begin
          miscompares++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                   waddr, wdata, exp[39:32], exp[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  t;
    bit  acc;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    forever begin
      @(negedge clk);
      acc = (rx_ready === 1'b1);
      tick();
      if (acc) break;
      t++;
      if (t > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: byte %h not accepted, rx_ready=%b, required 1", b, rx_ready);
        break;
      end
    end
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
  endtask

  task automatic send_frame(input bit gaps);
    while (fq.size() > 0) send_byte(fq.pop_front(), gaps);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, rx_ready, done, err_code, core_rst} !== 6'b110001) begin
      miscompares++;
      $display("FAIL start_state: got busy=%b rdy=%b done=%b err=%b crst=%b, required 1 1 0 00 1",
               busy, rx_ready, done, err_code, core_rst);
    end
  endtask

  task automatic expect_status(input string name, input logic d, input logic [1:0] e,
                               input logic cr, input logic rdy);
    vectors++;
    if ({done, err_code, core_rst, rx_ready, busy} !== {d, e, cr, rdy, rdy}) begin
      miscompares++;
      $display("FAIL %s: got done=%b err=%b crst=%b rdy=%b busy=%b, required done=%b err=%b crst=%b rdy=%b busy=%b",
               name, done, err_code, core_rst, rx_ready, busy, d, e, cr, rdy, rdy);
    end
  endtask

  task automatic drain(input string name);
    repeat (4) tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_writes: got %0d writes missing, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    vectors++;
    if ({rx_ready, we, waddr, wdata, busy, done, err_code, core_rst} !== {1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 2'b00, 1'b1}) begin
      miscompares++;
      $display("FAIL reset: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b crst=%b, required 0 0 00 00000000 0 0 00 1",
               rx_ready, we, waddr, wdata, busy, done, err_code, core_rst);
    end
  endtask

  task automatic test_single_word();
    do_start();
    fq = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7};
    sb.push_back({8'd0, 32'h00A00513});
    send_frame(1'b0);
    expect_status("single_word", 1'b1, 2'b00, 1'b0, 1'b0);
    drain("single_word");
  endtask

  task automatic test_empty();
    do_start();
    fq = '{8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    expect_status("empty", 1'b1, 2'b00, 1'b0, 1'b0);
    drain("empty");
  endtask

  task automatic test_oversize();
    do_start();
    fq = '{8'h01, 8'h01};
    send_frame(1'b0);
    expect_status("oversize", 1'b0, 2'b01, 1'b1, 1'b0);
    drain("oversize");
  endtask

  task automatic test_bad_csum();
    do_start();
    fq = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
    sb.push_back({8'd0, 32'h00A00513});
    send_frame(1'b0);
    expect_status("bad_csum", 1'b0, 2'b10, 1'b1, 1'b0);
    drain("bad_csum");
  endtask

  task automatic test_backpressure();
    do_start();
    fq = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    sb.push_back({8'd0, 32'h04030201});
    sb.push_back({8'd1, 32'h08070605});
    send_frame(1'b1);
    expect_status("backpressure", 1'b1, 2'b00, 1'b0, 1'b0);
    drain("backpressure");
  endtask

  task automatic test_max_len();
    logic [7:0] cs;
    logic [7:0] b[4];
    do_start();
    fq = '{8'h00, 8'h01};
    cs = 8'h01;
    for (int unsigned i = 0; i < 256; i++) begin
      b[0] = 8'(i); b[1] = 8'(i + 1); b[2] = ~8'(i); b[3] = 8'hC3;
      for (int unsigned k = 0; k < 4; k++) begin
        fq.push_back(b[k]);
        cs ^= b[k];
      end
      sb.push_back({8'(i), b[3], b[2], b[1], b[0]});
    end
    fq.push_back(cs);
    send_frame(1'b0);
    expect_status("max_len", 1'b1, 2'b00, 1'b0, 1'b0);
    drain("max_len");
  endtask

  task automatic test_reset_mid_load();
    do_start();
    fq = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    send_frame(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({rx_ready, we, waddr, wdata, busy, done, err_code, core_rst} !== {1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 2'b00, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_reset: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b crst=%b, required 0 0 00 00000000 0 0 00 1",
               rx_ready, we, waddr, wdata, busy, done, err_code, core_rst);
    end
    drain("mid_reset");
    do_start();
    fq = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    sb.push_back({8'd0, 32'h12345678});
    send_frame(1'b0);
    expect_status("after_reset", 1'b1, 2'b00, 1'b0, 1'b0);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_empty();
    test_oversize();
    test_bad_csum();
    test_backpressure();
    test_max_len();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
